// File: rtl/dmem_pkg.sv
// Shared state type, address constants and address decode for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  typedef struct packed {
    logic [31:0] index;
    logic        error;
  } addr_dec_t;

  // Misaligned or beyond the last word is an error; the address is unsigned.
  function automatic addr_dec_t decode_addr(input logic [31:0] addr, input int unsigned depth);
    addr_dec_t   dec;
    logic [33:0] limit;
    limit     = 34'(depth) * 34'(WORD_BYTES);
    dec.index = addr >> ADDR_LSB;
    dec.error = (addr[ADDR_LSB-1:0] != '0) || ({2'b00, addr} >= limit);
    return dec;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: synchronous byte-masked write, combinational read, no reset.
module dmem_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 32
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [DATA_WIDTH/8-1:0]       wbe_i,
  output logic [DATA_WIDTH-1:0]         rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wbe_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Latency-modelling data-memory responder with request/response valid/ready channels.
// Optional per-byte store enables (port req_be) when DMEM_BYTE_ENABLE_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
  input  logic [DATA_WIDTH/8-1:0] req_be,
`endif
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_error,
  output logic                    busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  write_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0]         be_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic                  do_access;
  logic                  from_idle;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [BW-1:0]         acc_be;
  logic [BW-1:0]         be_in;
  addr_dec_t             dec;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  unused_idx_bits;

`ifdef DMEM_BYTE_ENABLE_EN
  assign be_in = req_be;
`else
  assign be_in = '1;
`endif

  // With zero wait cycles the access happens on the accepting edge, so use the live request.
  assign from_idle = (state_q == IDLE);
  assign acc_write = from_idle ? req_write : write_q;
  assign acc_addr  = from_idle ? req_addr  : addr_q;
  assign acc_wdata = from_idle ? req_wdata : wdata_q;
  assign acc_be    = from_idle ? be_in     : be_q;

  assign dec             = decode_addr(acc_addr, DEPTH_WORDS);
  assign unused_idx_bits = ^dec.index[31:AW];

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clock),
    .we_i   (do_access && acc_write && !dec.error),
    .addr_i (dec.index[AW-1:0]),
    .wdata_i(acc_wdata),
    .wbe_i  (acc_be),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d   = RESP;
            do_access = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d   = RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    error_d = error_q;
    if (do_access) begin
      rdata_d = (acc_write || dec.error) ? '0 : arr_rdata;
      error_d = dec.error;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (from_idle && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= be_in;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule
